// File: rtl/if_pkg.sv
// Shared definitions for the Instruction Fetch stage: PC state encoding and instruction size.
package if_pkg;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_RUN  = 2'b01;
    localparam logic [1:0] PC_HALT = 2'b10;

    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        StBoot = PC_BOOT,
        StRun  = PC_RUN,
        StHalt = PC_HALT
    } pc_state_e;

endpackage

// File: rtl/pc_target_check.sv
// Combinational legality check of a fetch target against the instruction memory size.
// Also intended for reuse by the IMEM bounds checker.
module pc_target_check
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              legal_o,
    output logic              misalign_o
);

    // Highest address holding a whole instruction; ADDR_W+1 bits so IMEM_BYTES = 2^ADDR_W fits.
    localparam logic [ADDR_W:0] MaxAddr = (ADDR_W+1)'(IMEM_BYTES - INSN_BYTES);

    logic w_in_range;

    // Alignment and range decode of the target address.
    always_comb begin
        misalign_o = |addr_i[1:0];
        w_in_range = ({1'b0, addr_i} <= MaxAddr);
        legal_o    = !misalign_o && w_in_range;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter for the Instruction Fetch stage: boot/run/halt FSM, stall hold,
// prioritised redirect with fault trapping, wrapped sequential increment.
// Optional simulation trace with fetch counter when PC_TRACE_EN is defined.
module pc_unit
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned IMEM_BYTES = 256,
    parameter int unsigned RESET_VEC  = 0,
    parameter int unsigned TRAP_VEC   = 252,
    parameter int unsigned INC        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    input  logic              halt_i,
    input  logic              resume_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus_o,
    output logic              fetch_valid_o,
    output logic              fault_o,
    output logic              misalign_o,
    output logic [1:0]        state_o
);

    localparam logic [ADDR_W-1:0] ResetPc  = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] TrapPc   = ADDR_W'(TRAP_VEC);
    localparam logic [ADDR_W:0]   IncW     = (ADDR_W+1)'(INC);
    localparam logic [ADDR_W:0]   MemLimit = (ADDR_W+1)'(IMEM_BYTES);

    pc_state_e         r_state, w_state_d;
    logic [ADDR_W-1:0] r_pc, w_pc_d;
    logic              r_fault, w_fault_d;
    logic              r_misalign, w_misalign_d;

    logic [ADDR_W:0]   w_sum;
    logic              w_tgt_legal;
    logic              w_tgt_misalign;

    pc_target_check #(
        .ADDR_W     (ADDR_W),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_target_check (
        .addr_i     (redirect_addr_i),
        .legal_o    (w_tgt_legal),
        .misalign_o (w_tgt_misalign)
    );

    // Sequential successor, wrapped to 0 once it would leave instruction memory.
    always_comb begin
        w_sum     = {1'b0, r_pc} + IncW;
        pc_plus_o = (w_sum >= MemLimit) ? '0 : w_sum[ADDR_W-1:0];
    end

    // Next-state, next-PC and fault decode; fetch qualifier.
    always_comb begin
        w_state_d     = r_state;
        w_pc_d        = r_pc;
        w_fault_d     = 1'b0;
        w_misalign_d  = 1'b0;
        fetch_valid_o = 1'b0;

        unique case (r_state)
            StBoot: begin
                w_state_d = StRun;
            end
            StRun: begin
                fetch_valid_o = !stall_i;
                if (halt_i) begin
                    // Redirect in the halting cycle is dropped.
                    w_state_d = StHalt;
                end else if (redirect_valid_i) begin
                    if (w_tgt_legal) begin
                        w_pc_d = redirect_addr_i;
                    end else begin
                        w_pc_d       = TrapPc;
                        w_fault_d    = 1'b1;
                        w_misalign_d = w_tgt_misalign;
                    end
                end else if (!stall_i) begin
                    w_pc_d = pc_plus_o;
                end
            end
            StHalt: begin
                // Debugger set-PC: same trap rules as in RUN; halt_i is ignored here.
                if (redirect_valid_i) begin
                    if (w_tgt_legal) begin
                        w_pc_d = redirect_addr_i;
                    end else begin
                        w_pc_d       = TrapPc;
                        w_fault_d    = 1'b1;
                        w_misalign_d = w_tgt_misalign;
                    end
                end
                if (resume_i) begin
                    w_state_d = StRun;
                end
            end
            default: begin
                w_state_d = StBoot;
                w_pc_d    = ResetPc;
            end
        endcase
    end

    // State, PC and fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StBoot;
            r_pc       <= ResetPc;
            r_fault    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_fault    <= w_fault_d;
            r_misalign <= w_misalign_d;
        end
    end

    assign pc_o       = r_pc;
    assign fault_o    = r_fault;
    assign misalign_o = r_misalign;
    assign state_o    = r_state;

`ifdef PC_TRACE_EN
    logic [31:0] r_fetch_cnt;

    // Count cycles that issue a real fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
        end else if (fetch_valid_o) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    // Simulation-only trace of the updated PC shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            $display("----------------------------------------");
            $display("PC updated to %0d state=%b fetches=%0d", pc_o, state_o, r_fetch_cnt);
            if (fault_o) begin
                $display("trap cause: %s", misalign_o ? "misaligned" : "out of range");
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: expected post-edge values go into a scoreboard queue when
// each cycle's stimulus is driven and are popped and compared after the edge.
module tb_pc_unit;

    localparam logic [1:0] SBoot = 2'b00;
    localparam logic [1:0] SRun  = 2'b01;
    localparam logic [1:0] SHalt = 2'b10;

    typedef struct {
        logic [7:0] pc;
        logic [1:0] st;
        logic       flt;
        logic       mis;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall_i = 1'b0;
    logic       redirect_valid_i = 1'b0;
    logic [7:0] redirect_addr_i = '0;
    logic       halt_i = 1'b0;
    logic       resume_i = 1'b0;

    logic [7:0] pc_o, pc_plus_o;
    logic       fetch_valid_o, fault_o, misalign_o;
    logic [1:0] state_o;

    // Second instance with a 128-byte memory for the out-of-range trap.
    logic [7:0] s_pc, s_pc_plus;
    logic       s_fv, s_fault, s_mis;
    logic [1:0] s_state;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_pc = 0;
    exp_t exp_q[$];

    pc_unit u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_addr_i  (redirect_addr_i),
        .halt_i           (halt_i),
        .resume_i         (resume_i),
        .pc_o             (pc_o),
        .pc_plus_o        (pc_plus_o),
        .fetch_valid_o    (fetch_valid_o),
        .fault_o          (fault_o),
        .misalign_o       (misalign_o),
        .state_o          (state_o)
    );

    pc_unit #(
        .IMEM_BYTES (128),
        .TRAP_VEC   (124)
    ) u_dut_small (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_addr_i  (redirect_addr_i),
        .halt_i           (halt_i),
        .resume_i         (resume_i),
        .pc_o             (s_pc),
        .pc_plus_o        (s_pc_plus),
        .fetch_valid_o    (s_fv),
        .fault_o          (s_fault),
        .misalign_o       (s_mis),
        .state_o          (s_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int plus_of(input int p);
        return (p + 4 >= 256) ? 0 : p + 4;
    endfunction

    // One clock: drive inputs, check combinational outputs mid-cycle, queue and check registers.
    task automatic cycle(input string tag, input logic st, input logic rv, input logic [7:0] ra,
                         input logic hl, input logic rs, input logic exp_fv,
                         input logic [7:0] exp_pc, input logic [1:0] exp_st,
                         input logic exp_flt, input logic exp_mis);
        exp_t e;
        stall_i          = st;
        redirect_valid_i = rv;
        redirect_addr_i  = ra;
        halt_i           = hl;
        resume_i         = rs;
        @(negedge clk);
        check_eq({tag, ".fv"}, 32'(fetch_valid_o), 32'(exp_fv));
        check_eq({tag, ".plus"}, 32'(pc_plus_o), 32'(plus_of(cur_pc)));
        e.pc  = exp_pc;
        e.st  = exp_st;
        e.flt = exp_flt;
        e.mis = exp_mis;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, ".pc"}, 32'(pc_o), 32'(e.pc));
        check_eq({tag, ".state"}, 32'(state_o), 32'(e.st));
        check_eq({tag, ".fault"}, 32'(fault_o), 32'(e.flt));
        check_eq({tag, ".mis"}, 32'(misalign_o), 32'(e.mis));
        cur_pc = int'(exp_pc);
    endtask

    initial begin
        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.pc", 32'(pc_o), 32'd0);
        check_eq("rst.state", 32'(state_o), 32'(SBoot));
        check_eq("rst.fv", 32'(fetch_valid_o), 32'd0);
        check_eq("rst.fault", 32'(fault_o), 32'd0);
        rst_n = 1'b1;

        //     tag      st   rv   addr   hl   rs   fv   pc    state flt mis
        cycle("boot",  0,   0,   8'd0,  0,   0,   0,   8'd0,  SRun, 0, 0);
        cycle("seq0",  0,   0,   8'd0,  0,   0,   1,   8'd4,  SRun, 0, 0);
        cycle("seq1",  0,   0,   8'd0,  0,   0,   1,   8'd8,  SRun, 0, 0);
        cycle("seq2",  0,   0,   8'd0,  0,   0,   1,   8'd12, SRun, 0, 0);
        cycle("seq3",  0,   0,   8'd0,  0,   0,   1,   8'd16, SRun, 0, 0);
        cycle("stl0",  1,   0,   8'd0,  0,   0,   0,   8'd16, SRun, 0, 0);
        cycle("stl1",  1,   0,   8'd0,  0,   0,   0,   8'd16, SRun, 0, 0);
        cycle("stlrd", 1,   1,   8'd40, 0,   0,   0,   8'd40, SRun, 0, 0);
        cycle("mis",   0,   1,   8'h22, 0,   0,   1,   8'd252, SRun, 1, 1);
        cycle("wrap",  0,   0,   8'd0,  0,   0,   1,   8'd0,  SRun, 0, 0);
        cycle("seq4",  0,   0,   8'd0,  0,   0,   1,   8'd4,  SRun, 0, 0);
        cycle("seq5",  0,   0,   8'd0,  0,   0,   1,   8'd8,  SRun, 0, 0);
        cycle("halt",  0,   1,   8'd100, 1,  0,   1,   8'd8,  SHalt, 0, 0);
        cycle("hld0",  0,   0,   8'd0,  0,   0,   0,   8'd8,  SHalt, 0, 0);
        cycle("hld1",  1,   0,   8'd0,  0,   0,   0,   8'd8,  SHalt, 0, 0);
        cycle("hld2",  0,   0,   8'd0,  1,   0,   0,   8'd8,  SHalt, 0, 0);
        cycle("hld3",  0,   0,   8'd0,  0,   0,   0,   8'd8,  SHalt, 0, 0);
        cycle("hsetpc", 0,  1,   8'd64, 0,   0,   0,   8'd64, SHalt, 0, 0);
        cycle("resume", 0,  0,   8'd0,  1,   1,   0,   8'd64, SRun, 0, 0);
        cycle("seq6",  0,   0,   8'd0,  0,   0,   1,   8'd68, SRun, 0, 0);
        cycle("rd200", 0,   1,   8'd200, 0,  0,   1,   8'd200, SRun, 0, 0);
        check_eq("small.pc", 32'(s_pc), 32'd124);
        check_eq("small.state", 32'(s_state), 32'(SRun));
        check_eq("small.fault", 32'(s_fault), 32'd1);
        check_eq("small.mis", 32'(s_mis), 32'd0);
        cycle("seq7",  0,   0,   8'd0,  0,   0,   1,   8'd204, SRun, 0, 0);
        check_eq("small.fault_clr", 32'(s_fault), 32'd0);
        check_eq("small.wrap", 32'(s_pc), 32'd0);
        cycle("rd100", 0,   1,   8'd100, 0,  0,   1,   8'd100, SRun, 0, 0);
        cycle("stl2",  1,   0,   8'd0,  0,   0,   0,   8'd100, SRun, 0, 0);

        // Asynchronous reset between edges while stalled.
        stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.pc", 32'(pc_o), 32'd0);
        check_eq("arst.state", 32'(state_o), 32'(SBoot));
        check_eq("arst.fv", 32'(fetch_valid_o), 32'd0);
        @(posedge clk);
        #1;
        check_eq("arst.hold", 32'(pc_o), 32'd0);
        rst_n = 1'b1;
        cur_pc = 0;
        cycle("reboot", 0,  0,   8'd0,  0,   0,   0,   8'd0,  SRun, 0, 0);
        cycle("reseq", 0,   0,   8'd0,  0,   0,   1,   8'd4,  SRun, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
